// File: rtl/wb_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Source encodings, default widths and the hard-wired zero register.
package wb_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_out_reg.sv
// Load-enabled output register with synchronous active-high clear.
// Clear takes precedence over the load enable.
module wb_out_reg #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] reg_d;
  logic [W-1:0] reg_q;

  always_comb begin
    reg_d = reg_q;
    if (en) reg_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) reg_q <= '0;
    else     reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (B) paths.
// Round-robin or fixed-priority grant; the winning write is registered onto the port.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int FIXED_PRI = 0
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          A_Valid,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_Data,
  output logic          A_Ready,
  input  logic          B_Valid,
  input  logic [AW-1:0] B_Addr,
  input  logic [DW-1:0] B_Data,
  output logic          B_Ready,
  input  logic          Hold,
  output logic          WE,
  output logic [AW-1:0] WAddr,
  output logic [DW-1:0] WData,
  output logic          WSrc
);

  localparam int OW = AW + DW + 2;

  logic          grant_a;
  logic          grant_b;
  logic          pri_d;
  logic          pri_q;
  logic [OW-1:0] out_d;
  logic [OW-1:0] out_q;

  always_comb begin
    grant_a = A_Valid & (!B_Valid | (FIXED_PRI != 0) | (pri_q == SRC_A));
    grant_b = B_Valid & !grant_a;
    A_Ready = grant_a & !Hold & !Clr;
    B_Ready = grant_b & !Hold & !Clr;
  end

  // Pointer moves to the loser only on a completed transfer, so Hold freezes it too.
  always_comb begin
    pri_d = pri_q;
    if (FIXED_PRI == 0) begin
      if (A_Ready)      pri_d = SRC_B;
      else if (B_Ready) pri_d = SRC_A;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) pri_q <= SRC_A;
    else     pri_q <= pri_d;
  end

  // r0 writes finish the handshake but leave the strobe low.
  always_comb begin
    out_d = {1'b0, out_q[OW-2:0]};
    if (A_Ready)
      out_d = {(A_Addr != AW'(REG_ZERO)), SRC_A, A_Addr, A_Data};
    else if (B_Ready)
      out_d = {(B_Addr != AW'(REG_ZERO)), SRC_B, B_Addr, B_Data};
  end

  wb_out_reg #(
    .W(OW)
  ) u_out_reg (
    .clk(Clk),
    .clr(Clr),
    .en (!Hold),
    .d  (out_d),
    .q  (out_q)
  );

  assign {WE, WSrc, WAddr, WData} = out_q;

endmodule
